// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the DDR2 local-interface arbiter.
//   DEF_DDR_ADDR_WIDTH / DEF_DDR_DATA_WIDTH : default local_address / data widths
//   arb_state_e                             : issue FSM states
//   req_id_t, REQ_A, REQ_B                  : requester identifier carried in read tags
package ddr_arb_pkg;

    localparam int unsigned DEF_DDR_ADDR_WIDTH = 26;
    localparam int unsigned DEF_DDR_DATA_WIDTH = 128;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/ddr_local_arb_if.sv
// Bundle of the two requester channels and the DDR2 controller local interface.
//   a_* / b_*   : valid/ready request channels plus per-requester read-data strobes
//   rdata       : read data shared by both requesters
//   local_*     : controller side (init_done, ready, rdata in; address, wdata, req strobes out)
// Modport slave is the arbiter's view; master is the view of requesters plus controller.
interface ddr_local_arb_if
    import ddr_arb_pkg::*;
#(
    parameter int unsigned DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
    parameter int unsigned DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH
);
    logic                      a_valid;
    logic                      a_wr;
    logic [DDR_ADDR_WIDTH-1:0] a_addr;
    logic [DDR_DATA_WIDTH-1:0] a_wdata;
    logic                      a_ready;
    logic                      a_rdata_valid;

    logic                      b_valid;
    logic                      b_wr;
    logic [DDR_ADDR_WIDTH-1:0] b_addr;
    logic [DDR_DATA_WIDTH-1:0] b_wdata;
    logic                      b_ready;
    logic                      b_rdata_valid;

    logic [DDR_DATA_WIDTH-1:0] rdata;

    logic                      local_init_done;
    logic                      local_ready;
    logic [DDR_DATA_WIDTH-1:0] local_rdata;
    logic                      local_rdata_valid;
    logic [DDR_ADDR_WIDTH-1:0] local_address;
    logic [DDR_DATA_WIDTH-1:0] local_wdata;
    logic                      local_write_req;
    logic                      local_read_req;
    logic                      local_burstbegin;

    modport slave (
        input  a_valid, a_wr, a_addr, a_wdata,
        input  b_valid, b_wr, b_addr, b_wdata,
        input  local_init_done, local_ready, local_rdata, local_rdata_valid,
        output a_ready, a_rdata_valid, b_ready, b_rdata_valid, rdata,
        output local_address, local_wdata, local_write_req, local_read_req, local_burstbegin
    );

    modport master (
        output a_valid, a_wr, a_addr, a_wdata,
        output b_valid, b_wr, b_addr, b_wdata,
        output local_init_done, local_ready, local_rdata, local_rdata_valid,
        input  a_ready, a_rdata_valid, b_ready, b_rdata_valid, rdata,
        input  local_address, local_wdata, local_write_req, local_read_req, local_burstbegin
    );

endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// Synchronous FIFO of requester ids for reads in flight.
//   phy_clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : enqueue an id (ignored when full unless popping in the same cycle)
//   pop, dout    : dequeue; dout is the current head
//   full, empty, count : occupancy, count updates the cycle after push/pop
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             phy_clk,
    input  logic             rst,
    input  logic             push,
    input  req_id_t          din,
    input  logic             pop,
    output req_id_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the simultaneous push lands in.
    assign do_push = push & (~full | pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge phy_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ddr_local_arb.sv
// Round-robin arbiter putting two requesters onto one DDR2 controller local interface.
//   phy_clk, rst     : clock, synchronous active-high reset
//   bus              : requester channels and controller local interface (slave modport)
//   rd_outstanding   : reads issued whose data has not yet returned
//   err_unexp_rdata  : sticky, local_rdata_valid arrived with no read outstanding
module ddr_local_arb
    import ddr_arb_pkg::*;
#(
    parameter int unsigned DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
    parameter int unsigned DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
    parameter int unsigned RD_TAG_DEPTH   = 8,
    localparam int unsigned CNT_W = $clog2(RD_TAG_DEPTH) + 1
) (
    input  logic             phy_clk,
    input  logic             rst,
    ddr_local_arb_if.slave   bus,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             err_unexp_rdata
);
    arb_state_e                state_q, state_d;
    req_id_t                   last_grant_q, last_grant_d;
    req_id_t                   id_q;
    logic                      wr_q;
    logic                      first_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [DDR_DATA_WIDTH-1:0] wdata_q;
    logic                      err_q;

    logic    a_elig, b_elig, grant_a, grant_b, issue_done;
    logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
    req_id_t fifo_head;

    always_comb begin
        a_elig       = bus.a_valid & (bus.a_wr | ~fifo_full) & bus.local_init_done;
        b_elig       = bus.b_valid & (bus.b_wr | ~fifo_full) & bus.local_init_done;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        issue_done   = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                // On a tie the requester not served last wins.
                if (a_elig && (!b_elig || last_grant_q == REQ_B)) begin
                    grant_a = 1'b1;
                end else if (b_elig) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_d      = StIssue;
                    last_grant_d = grant_a ? REQ_A : REQ_B;
                end
            end
            StIssue: begin
                if (bus.local_ready) begin
                    issue_done = 1'b1;
                    state_d    = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= REQ_B;
            id_q         <= REQ_A;
            wr_q         <= 1'b0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            // Burst begin marks only the first cycle after a grant.
            first_q      <= grant_a | grant_b;
            if (grant_a) begin
                id_q    <= REQ_A;
                wr_q    <= bus.a_wr;
                addr_q  <= bus.a_addr;
                wdata_q <= bus.a_wdata;
            end else if (grant_b) begin
                id_q    <= REQ_B;
                wr_q    <= bus.b_wr;
                addr_q  <= bus.b_addr;
                wdata_q <= bus.b_wdata;
            end
            if (bus.local_rdata_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fifo_push = issue_done & ~wr_q;
    assign fifo_pop  = bus.local_rdata_valid & ~fifo_empty;

    ddr_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH)
    ) u_tag_fifo (
        .phy_clk (phy_clk),
        .rst     (rst),
        .push    (fifo_push),
        .din     (id_q),
        .pop     (fifo_pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rd_outstanding)
    );

    assign bus.a_ready          = grant_a;
    assign bus.b_ready          = grant_b;
    assign bus.local_address    = addr_q;
    assign bus.local_wdata      = wdata_q;
    assign bus.local_write_req  = (state_q == StIssue) & wr_q;
    assign bus.local_read_req   = (state_q == StIssue) & ~wr_q;
    assign bus.local_burstbegin = first_q;
    assign bus.rdata            = bus.local_rdata;
    assign bus.a_rdata_valid    = fifo_pop & (fifo_head == REQ_A);
    assign bus.b_rdata_valid    = fifo_pop & (fifo_head == REQ_B);
    assign err_unexp_rdata      = err_q;

endmodule

// File: doc/ddr_local_arb.md
# ddr_local_arb

Two-requester arbiter sharing the DDR2 controller local interface (phy_clk domain) between the SoC command/buffer engine (port A) and an accelerator DMA master (port B). Each requester gets a valid/ready request channel; the block serialises requests onto local_* with round-robin fairness. It also tags every issued read so in-order local_rdata returns are steered to the requester that issued them.

## Interface
- DDR_ADDR_WIDTH, 26, local_address width
- DDR_DATA_WIDTH, 128, local_wdata/local_rdata width
- RD_TAG_DEPTH, 8, max outstanding reads (power of 2, ≥2)
- phy_clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid / b_valid  in  1  request present
- a_wr / b_wr  in  1  1 = write, 0 = read
- a_addr / b_addr  in  DDR_ADDR_WIDTH  local word address
- a_wdata / b_wdata  in  DDR_DATA_WIDTH  write data
- a_ready / b_ready  out  1  request accepted this cycle (valid&ready = transfer)
- a_rdata_valid / b_rdata_valid  out  1  read data for this requester
- rdata  out  DDR_DATA_WIDTH  = local_rdata, shared
- local_init_done  in  1  controller calibrated
- local_ready  in  1  controller accepts current request
- local_rdata  in  DDR_DATA_WIDTH; local_rdata_valid  in  1
- local_address  out  DDR_ADDR_WIDTH; local_wdata  out  DDR_DATA_WIDTH
- local_write_req / local_read_req / local_burstbegin  out  1 each
- rd_outstanding  out  $clog2(RD_TAG_DEPTH)+1  tags in flight
- err_unexp_rdata  out  1  sticky: local_rdata_valid with no tag

## Operation
- FSM: IDLE, ISSUE. Reset → IDLE.
- IDLE: requester eligible if valid & (wr | rd_outstanding < RD_TAG_DEPTH) & local_init_done. Pick eligible requester; tie broken round-robin against last_grant (reset value B, so A wins first tie). Assert chosen *_ready combinationally, capture addr/wdata/wr/id into registers, update last_grant, go ISSUE.
- ISSUE: drive local_address/local_wdata from capture regs; local_write_req or local_read_req = 1 held until local_ready; local_burstbegin = 1 on first ISSUE cycle only. Cycle with local_ready=1: request done; if read, push id into tag FIFO; → IDLE.
- Read return: on local_rdata_valid, pop FIFO head; head==A → a_rdata_valid=1, head==B → b_rdata_valid=1 (same cycle, combinational). FIFO empty → no rdata_valid out, set err_unexp_rdata.
- Push and pop same cycle: count unchanged, both honoured.
- Writes never blocked by FIFO full; reads blocked only while full.
- local_init_done low: no grants; an ISSUE already in progress completes.
- Requester must hold valid/wr/addr/wdata stable until ready; valid may drop only after transfer.

## Timing
- Reset values: all *_ready, *_rdata_valid, local_*_req, local_burstbegin = 0; local_address/wdata = 0; rd_outstanding = 0; err_unexp_rdata = 0; FIFO empty.
- Grant → local request: 1 cycle (ready in cycle N, local_*_req from N+1).
- Min spacing: one transfer per 2 cycles (ISSUE with local_ready=1, then IDLE).
- Read data: zero added latency on return path.
- rd_outstanding updates the cycle after push/pop.
- Reset mid-ISSUE: request dropped next edge, FIFO cleared; DDR side must be reset concurrently, otherwise stale returns set err_unexp_rdata.

## Structure
- Package ddr_arb_pkg: DDR_ADDR_WIDTH/DDR_DATA_WIDTH defaults, FSM state enum (IDLE, ISSUE), requester id type and constants REQ_A=0, REQ_B=1.
- Sub-module ddr_arb_tag_fifo: 1-bit wide, RD_TAG_DEPTH deep, sync FIFO with count, full, empty; simultaneous push/pop legal.

## Test plan
- Single write A addr 0x0000010, wdata 0x…AA, local_ready=1 → a_ready cycle N, local_write_req+burstbegin cycle N+1, one cycle only.
- A and B valid together, both reads, 4 each → grants alternate A,B,A,B…; tag order A,B,A,B; returned data routed to a/b_rdata_valid in same order.
- local_ready held low 5 cycles during ISSUE → req and address stable 6 cycles, burstbegin only first cycle.
- 8 reads from B with no return → rd_outstanding=8, further B reads stall, A write still granted; one rdata_valid → count 7, B read granted.
- local_rdata_valid with empty FIFO → err_unexp_rdata=1, no *_rdata_valid, stays 1 until rst.
- local_init_done=0 with A valid → no a_ready; init_done rises → a_ready next evaluation cycle.
